// File: rtl/uart_pkg.sv
// Shared types and constants for the UART I/O controller slice.
package uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud
  localparam int DEF_RXQ_DEPTH    = 16;

  // Request kind, sampled together with uart_go.
  localparam logic SEND = 1'b1;
  localparam logic RECV = 1'b0;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_io_ctrl_if.sv
// CPU-side request/response bundle of the UART controller.
interface uart_io_ctrl_if;
  logic       uart_go;
  logic       rors;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       uart_done;

  modport master (output uart_go, output rors, output tx_data,
                  input  rx_data, input  uart_done);
  modport slave  (input  uart_go, input  rors, input  tx_data,
                  output rx_data, output uart_done);
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte queue: power-of-two depth, head visible combinationally.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A push into a full queue is accepted only when a pop frees the slot in the same cycle.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/uart_io_ctrl.sv
// UART byte transmitter/receiver serving one CPU request at a time.
//
// state    | meaning
// TX_IDLE  | line high, waiting for a send request
// TX_START | driving the start bit
// TX_DATA  | driving data bit tx_idx, LSB first
// TX_STOP  | driving the stop bit
// RX_IDLE  | waiting for a falling edge on the synchronized line
// RX_START | counting to the start-bit mid-point to reject glitches
// RX_DATA  | sampling data bits at their mid-points
// RX_STOP  | sampling the stop bit, then push or flag framing error
module uart_io_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int RXQ_DEPTH    = DEF_RXQ_DEPTH
) (
  input  logic          clk,
  input  logic          rstn,
  uart_io_ctrl_if.slave bus,
  output logic          txd,
  input  logic          rxd,
  output logic          frame_err,
  output logic          overrun
);
  localparam int CW  = 16;
  localparam int QCW = $clog2(RXQ_DEPTH) + 1;
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);

  tx_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          txd_q, txd_d;
  logic          tx_done;

  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic          rx_push_v, rx_stop_bad;

  logic          rx_pend_q, rx_pend_d;
  logic          uart_done_q, uart_done_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;

  logic          go_ok, send_go, recv_go;
  logic          q_push, q_pop, q_full, q_empty, bypass;
  logic [7:0]    q_head;
  logic [QCW-1:0] q_count;

  // A request is outstanding from acceptance through its done cycle.
  assign go_ok   = bus.uart_go && (tx_state_q == TX_IDLE) && !rx_pend_q && !uart_done_q;
  assign send_go = go_ok && (bus.rors == SEND);
  assign recv_go = go_ok && (bus.rors == RECV);

  // Transmit sequencing; txd is registered from the next-state values so it has no glitches.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_byte_d  = tx_byte_q;
    tx_done    = 1'b0;
    case (tx_state_q)
      TX_IDLE: if (send_go) begin
        tx_state_d = TX_START;
        tx_byte_d  = bus.tx_data;
        tx_cnt_d   = BIT_RELOAD;
      end
      TX_START: if (tx_cnt_q == '0) begin
        tx_state_d = TX_DATA;
        tx_cnt_d   = BIT_RELOAD;
        tx_idx_d   = '0;
      end else tx_cnt_d = tx_cnt_q - CW'(1);
      TX_DATA: if (tx_cnt_q == '0) begin
        tx_cnt_d = BIT_RELOAD;
        if (tx_idx_q == 3'd7) tx_state_d = TX_STOP;
        else                  tx_idx_d   = tx_idx_q + 3'd1;
      end else tx_cnt_d = tx_cnt_q - CW'(1);
      TX_STOP: if (tx_cnt_q == '0) begin
        tx_state_d = TX_IDLE;
        tx_done    = 1'b1;
      end else tx_cnt_d = tx_cnt_q - CW'(1);
      default: tx_state_d = TX_IDLE;
    endcase
    txd_d = 1'b1;
    case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_byte_d[tx_idx_d];
      default:  txd_d = 1'b1;
    endcase
  end

  // Receive sequencing on the synchronized line, sampling at bit mid-points.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_idx_d    = rx_idx_q;
    rx_shift_d  = rx_shift_q;
    rx_push_v   = 1'b0;
    rx_stop_bad = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_prev_q && !rx_sync2_q) begin
        rx_state_d = RX_START;
        rx_cnt_d   = HALF_RELOAD;
      end
      RX_START: if (rx_cnt_q == '0) begin
        if (rx_sync2_q) rx_state_d = RX_IDLE;
        else begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = BIT_RELOAD;
          rx_idx_d   = '0;
        end
      end else rx_cnt_d = rx_cnt_q - CW'(1);
      RX_DATA: if (rx_cnt_q == '0) begin
        rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
        rx_cnt_d   = BIT_RELOAD;
        if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
        else                  rx_idx_d   = rx_idx_q + 3'd1;
      end else rx_cnt_d = rx_cnt_q - CW'(1);
      RX_STOP: if (rx_cnt_q == '0) begin
        rx_state_d  = RX_IDLE;
        rx_push_v   = rx_sync2_q;
        rx_stop_bad = !rx_sync2_q;
      end else rx_cnt_d = rx_cnt_q - CW'(1);
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Request completion: pop a queued byte, or hand a fresh byte straight to a waiting reader.
  always_comb begin
    bypass      = rx_push_v && rx_pend_q && (q_count == '0);
    q_pop       = !q_empty && (recv_go || rx_pend_q);
    q_push      = rx_push_v && !bypass;
    rx_data_d   = rx_data_q;
    rx_pend_d   = rx_pend_q;
    if (q_pop) begin
      rx_data_d = q_head;
      rx_pend_d = 1'b0;
    end else if (bypass) begin
      rx_data_d = rx_shift_q;
      rx_pend_d = 1'b0;
    end else if (recv_go) begin
      rx_pend_d = 1'b1;
    end
    uart_done_d = tx_done || q_pop || bypass;
    frame_err_d = frame_err_q || rx_stop_bad;
    overrun_d   = overrun_q || (q_push && q_full && !q_pop);
  end

  // State registers for both FSMs and the CPU-facing outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      tx_byte_q   <= '0;
      txd_q       <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_idx_q    <= '0;
      rx_shift_q  <= '0;
      rx_pend_q   <= 1'b0;
      uart_done_q <= 1'b0;
      rx_data_q   <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      tx_byte_q   <= tx_byte_d;
      txd_q       <= txd_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_idx_q    <= rx_idx_d;
      rx_shift_q  <= rx_shift_d;
      rx_pend_q   <= rx_pend_d;
      uart_done_q <= uart_done_d;
      rx_data_q   <= rx_data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_sync1_q <= rxd;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
    end
  end

  uart_rx_fifo #(.DEPTH(RXQ_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (q_push),
    .push_data (rx_shift_q),
    .pop       (q_pop),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign txd           = txd_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.uart_done = uart_done_q;
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;
endmodule

// File: tb/tb_uart_io_ctrl.sv
// Self-checking bench for uart_io_ctrl with a queue-level receive model.
module tb_uart_io_ctrl;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rxd = 1'b1;
  logic txd, frame_err, overrun;

  uart_io_ctrl_if bus();

  uart_io_ctrl #(.CLKS_PER_BIT(CPB), .RXQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .bus(bus.slave), .txd(txd),
    .rxd(rxd), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [7:0] done_data = 8'h00;
  bit prev_done = 1'b0;
  bit dbl_done = 1'b0;

  // reference receive model: byte queue of DEPTH entries plus sticky flags
  logic [7:0] mq[$];
  bit m_ovr = 1'b0;
  bit m_ferr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.uart_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      done_data = bus.rx_data;
      if (prev_done) dbl_done = 1'b1;
    end
    prev_done = (bus.uart_done === 1'b1);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void model_frame(input logic [7:0] b, input bit stop);
    if (!stop) m_ferr = 1'b1;
    else if (mq.size() < DEPTH) mq.push_back(b);
    else m_ovr = 1'b1;
  endfunction

  task automatic do_reset();
    rstn = 1'b0; bus.uart_go = 1'b0; bus.rors = 1'b0; bus.tx_data = 8'h00; rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    mq.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] b, input bit stop, output int sc);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    @(posedge clk); #1;
    sc = cyc;
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rxd = 1'b1;
  endtask

  task automatic issue_read(output int g, output int d0);
    @(posedge clk); #1;
    bus.uart_go = 1'b1; bus.rors = RECV; g = cyc; d0 = done_cnt;
    @(posedge clk); #1;
    bus.uart_go = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit got);
    for (int w = 0; w < budget && done_cnt == d0; w++) begin
      @(negedge clk); #1;
    end
    got = (done_cnt != d0);
  endtask

  task automatic check_read(input logic [7:0] exp, input string tag);
    int g, d0; bit got;
    issue_read(g, d0);
    wait_done(d0, 8, got);
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL %s done: got 0 exp 1", tag); end
    n_cmp++;
    if (done_data !== exp) begin n_err++; $display("FAIL %s rx_data: got %h exp %h", tag, done_data, exp); end
    n_cmp++;
    if (done_cyc - g !== 1) begin n_err++; $display("FAIL %s latency: got %0d exp 1", tag, done_cyc - g); end
  endtask

  task automatic send_check(input logic [7:0] b, input string tag);
    logic [9:0] fr; logic [39:0] got; int g, d0;
    fr = {1'b1, b, 1'b0};
    @(posedge clk); #1;
    bus.uart_go = 1'b1; bus.rors = SEND; bus.tx_data = b; g = cyc; d0 = done_cnt;
    @(posedge clk); #1;
    bus.uart_go = 1'b0; bus.tx_data = ~b;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      got[k] = txd;
      if (k == 12) begin
        bus.uart_go = 1'b1; bus.rors = 1'($urandom_range(0, 1)); bus.tx_data = 8'($urandom);
      end
      if (k == 13) bus.uart_go = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (got[i*4 +: 4] !== {4{fr[i]}}) begin
        n_err++; $display("FAIL %s txd bit %0d: got %b exp %b", tag, i, got[i*4 +: 4], {4{fr[i]}});
      end
    end
    for (int w = 0; w < 10 && done_cnt == d0; w++) begin @(negedge clk); #1; end
    repeat (4) @(posedge clk); #1;
    n_cmp++;
    if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL %s done count: got %0d exp 1", tag, done_cnt - d0); end
    n_cmp++;
    if (done_cyc - g !== 10*CPB + 1) begin n_err++; $display("FAIL %s send latency: got %0d exp %0d", tag, done_cyc - g, 10*CPB + 1); end
    n_cmp++;
    if (txd !== 1'b1) begin n_err++; $display("FAIL %s txd idle: got %b exp 1", tag, txd); end
  endtask

  task automatic test_reset();
    rstn = 1'b0; bus.uart_go = 1'b0; bus.rors = 1'b0; bus.tx_data = 8'h00; rxd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL reset txd: got %b exp 1", txd); end
    n_cmp++; if (bus.uart_done !== 1'b0) begin n_err++; $display("FAIL reset uart_done: got %b exp 0", bus.uart_done); end
    n_cmp++; if (bus.rx_data !== 8'h00) begin n_err++; $display("FAIL reset rx_data: got %h exp 00", bus.rx_data); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset frame_err: got %b exp 0", frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset overrun: got %b exp 0", overrun); end
    do_reset();
  endtask

  task automatic test_send();
    do_reset();
    send_check(8'hA5, "send_a5");
    for (int i = 0; i < 3; i++) send_check(8'($urandom), "send_rand");
  endtask

  task automatic test_rx_queued();
    int sc;
    logic [7:0] b;
    do_reset();
    drive_frame(8'h3C, 1'b1, sc); model_frame(8'h3C, 1'b1);
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      drive_frame(b, 1'b1, sc); model_frame(b, 1'b1);
    end
    repeat (6) @(posedge clk);
    while (mq.size() > 0) check_read(mq.pop_front(), "rx_queued");
    n_cmp++; if (overrun !== m_ovr) begin n_err++; $display("FAIL rx_queued overrun: got %b exp %b", overrun, m_ovr); end
  endtask

  task automatic test_rx_pending();
    int g, d0, sc; bit got;
    logic [7:0] b;
    do_reset();
    issue_read(g, d0);
    repeat (8) @(negedge clk);
    #1;
    n_cmp++; if (done_cnt != d0) begin n_err++; $display("FAIL pend early done: got %0d exp 0", done_cnt - d0); end
    drive_frame(8'h7E, 1'b1, sc);
    wait_done(d0, 12, got);
    n_cmp++; if (!got) begin n_err++; $display("FAIL pend done: got 0 exp 1"); end
    n_cmp++; if (done_data !== 8'h7E) begin n_err++; $display("FAIL pend rx_data: got %h exp 7e", done_data); end
    n_cmp++;
    if (done_cyc - sc < 10*CPB || done_cyc - sc > 10*CPB + 3) begin
      n_err++; $display("FAIL pend latency: got %0d exp %0d..%0d", done_cyc - sc, 10*CPB, 10*CPB + 3);
    end
    // the delivered byte must not linger in the queue: another read has to wait
    repeat (3) @(posedge clk);
    issue_read(g, d0);
    repeat (12) @(negedge clk);
    #1;
    n_cmp++; if (done_cnt != d0) begin n_err++; $display("FAIL pend queue empty: got %0d done exp 0", done_cnt - d0); end
    b = 8'($urandom);
    drive_frame(b, 1'b1, sc);
    wait_done(d0, 12, got);
    n_cmp++; if (!got || done_data !== b) begin n_err++; $display("FAIL pend rand: got %h (done %b) exp %h", done_data, got, b); end
  endtask

  task automatic test_overrun();
    int sc;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive_frame(8'(i), 1'b1, sc); model_frame(8'(i), 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    repeat (6) @(posedge clk); #1;
    n_cmp++; if (overrun !== m_ovr) begin n_err++; $display("FAIL overrun flag: got %b exp %b", overrun, m_ovr); end
    while (mq.size() > 0) check_read(mq.pop_front(), "overrun_read");
    n_cmp++; if (frame_err !== m_ferr) begin n_err++; $display("FAIL overrun frame_err: got %b exp %b", frame_err, m_ferr); end
  endtask

  task automatic test_framing();
    int g, d0, sc; bit got;
    logic [7:0] b;
    do_reset();
    issue_read(g, d0);
    @(posedge clk); #1 rxd = 1'b0;
    @(posedge clk); #1 rxd = 1'b1;
    repeat (20) @(posedge clk); #1;
    n_cmp++; if (done_cnt != d0) begin n_err++; $display("FAIL glitch push: got %0d done exp 0", done_cnt - d0); end
    drive_frame(8'h55, 1'b0, sc); model_frame(8'h55, 1'b0);
    repeat (6) @(posedge clk); #1;
    n_cmp++; if (frame_err !== m_ferr) begin n_err++; $display("FAIL frame_err: got %b exp %b", frame_err, m_ferr); end
    n_cmp++; if (done_cnt != d0) begin n_err++; $display("FAIL bad frame push: got %0d done exp 0", done_cnt - d0); end
    b = 8'($urandom);
    drive_frame(b, 1'b1, sc);
    wait_done(d0, 12, got);
    n_cmp++; if (!got || done_data !== b) begin n_err++; $display("FAIL after frame_err: got %h (done %b) exp %h", done_data, got, b); end
    n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL frame_err sticky: got %b exp 1", frame_err); end
  endtask

  task automatic test_tx_reset();
    int d0, lows;
    do_reset();
    @(posedge clk); #1;
    bus.uart_go = 1'b1; bus.rors = SEND; bus.tx_data = 8'hAA;
    @(posedge clk); #1;
    bus.uart_go = 1'b0;
    repeat (20) @(posedge clk); #1;
    rstn = 1'b0; d0 = done_cnt;
    @(posedge clk); #1;
    n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL tx reset txd: got %b exp 1", txd); end
    rstn = 1'b1;
    lows = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (txd !== 1'b1) lows++;
    end
    n_cmp++; if (lows != 0) begin n_err++; $display("FAIL tx reset line: got %0d low cycles exp 0", lows); end
    n_cmp++; if (done_cnt != d0) begin n_err++; $display("FAIL tx reset done: got %0d exp 0", done_cnt - d0); end
    send_check(8'hFF, "send_ff_after_reset");
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    do_reset();
    fork
      send_check(8'($urandom), "send_during_rx");
      begin
        int sc;
        for (int i = 0; i < 3; i++) begin
          b = 8'($urandom);
          drive_frame(b, 1'b1, sc); model_frame(b, 1'b1);
        end
      end
    join
    repeat (6) @(posedge clk);
    while (mq.size() > 0) check_read(mq.pop_front(), "b2b_read");
    n_cmp++; if (overrun !== m_ovr) begin n_err++; $display("FAIL b2b overrun: got %b exp %b", overrun, m_ovr); end
  endtask

  initial begin
    bus.uart_go = 1'b0; bus.rors = 1'b0; bus.tx_data = 8'h00;
    test_reset();
    test_send();
    test_rx_queued();
    test_rx_pending();
    test_overrun();
    test_framing();
    test_tx_reset();
    test_back_to_back();
    n_cmp++;
    if (dbl_done !== 1'b0) begin n_err++; $display("FAIL uart_done width: got two-cycle pulse exp single"); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_io_ctrl.md
UART_IO_CTRL -- requirements
Module: uart_io_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200); legal range 4..65535.
REQ-002 Parameter RXQ_DEPTH, default 16, receive queue entries; power of two, 2..256.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 uart_go  input  1  one-cycle request strobe from the CPU control FSM.
REQ-006 rors  input  1  request kind, sampled with uart_go: 1 = send byte, 0 = receive byte.
REQ-007 tx_data  input  8  byte to send, sampled in the uart_go cycle.
REQ-008 rx_data  output  8  last received byte delivered to the CPU.
REQ-009 uart_done  output  1  one-cycle completion pulse for the pending request.
REQ-010 txd  output  1  serial transmit line, idle high.
REQ-011 rxd  input  1  serial receive line, asynchronous, idle high.
REQ-012 frame_err  output  1  sticky: a received stop bit sampled low.
REQ-013 overrun  output  1  sticky: a received byte was dropped because the queue was full.

Function
REQ-014 Frame format: 8N1, meaning 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit lasts exactly CLKS_PER_BIT cycles.
REQ-015 Transmit FSM states: TX_IDLE, TX_START, TX_DATA, TX_STOP; it uses a bit-period counter and a 3-bit bit index.
REQ-016 uart_go with rors=1 in TX_IDLE latches tx_data and enters TX_START; txd goes low in the following cycle.
REQ-017 TX_START lasts 1 bit period, then TX_DATA; TX_DATA lasts 8 bit periods, then TX_STOP.
REQ-018 TX_STOP drives txd=1 for 1 bit period; uart_done pulses in the cycle after the last stop cycle, and the FSM returns to TX_IDLE in that same cycle.
REQ-019 Send latency: uart_done is asserted exactly 10*CLKS_PER_BIT+1 cycles after the uart_go cycle.
REQ-020 Receive path: rxd passes through a 2-flop synchronizer before any use.
REQ-021 Receive FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
REQ-022 A synchronized 1->0 transition in RX_IDLE enters RX_START; the line is sampled at CLKS_PER_BIT/2 (integer division).
- Sample high: false start, return to RX_IDLE.
REQ-023 Data bits are sampled at successive CLKS_PER_BIT intervals after the start mid-point and shifted in LSB first.
REQ-024 Stop bit sampled 1: byte is pushed to the queue. Stop bit sampled 0: byte is discarded and frame_err is set. In both cases the FSM returns to RX_IDLE at the stop mid-point.
REQ-025 Push while queue full: byte dropped, overrun set, queue contents unchanged.
REQ-026 uart_go with rors=0 and queue non-empty: head is popped into rx_data in the next cycle, with uart_done pulsing in that same cycle (latency 1).
REQ-027 uart_go with rors=0 and queue empty: request stays pending; on the first push the pushed byte goes to rx_data and uart_done pulses in the cycle after the push, and the byte does not remain queued.
REQ-028 Simultaneous push and pop in the same cycle: both take effect and the occupancy count is unchanged; this also holds when the queue is full.
REQ-029 Queue pointers wrap modulo RXQ_DEPTH; the occupancy counter is $clog2(RXQ_DEPTH)+1 bits wide.
REQ-030 uart_go while a send or receive request is outstanding is ignored, with no state change.
REQ-031 A send and receive can never be outstanding together. Reception into the queue continues independently of transmit activity.
REQ-032 uart_done is never high for two consecutive cycles; rx_data holds its value between receive completions.

Reset
REQ-033 While rstn=0 at posedge clk:
- txd=1, uart_done=0, rx_data=8'h00, frame_err=0, overrun=0;
- queue empty, both FSMs idle, pending request cleared;
- synchronizer flops=1.
REQ-034 Reset mid-frame aborts the frame immediately. After reset, txd=1 and the partial rx byte is discarded; no uart_done is issued for the aborted request.

Structure
REQ-035 Shared package uart_pkg: tx_state_t and rx_state_t enums, default CLKS_PER_BIT and RXQ_DEPTH constants, and the rors encoding constants SEND=1 and RECV=0.
REQ-036 Sub-module uart_rx_fifo (RXQ_DEPTH x 8, push/pop/full/empty/count) is instantiated once; the TX and RX FSMs live in uart_io_ctrl.

Verification (bench CLKS_PER_BIT=4, RXQ_DEPTH=4)
REQ-037 Send: uart_go with rors=1 and tx_data=8'hA5 -> txd sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; uart_done exactly once, 41 cycles after go.
REQ-038 Receive, byte already queued: drive frame 8'h3C on rxd, then uart_go with rors=0 -> rx_data=8'h3C with uart_done in the next cycle.
REQ-039 Receive, queue empty: uart_go with rors=0 first, then drive 8'h7E -> uart_done one cycle after the stop mid-point with rx_data=8'h7E; queue remains empty.
REQ-040 Overrun: drive 5 frames 8'h01..8'h05 with no reads -> overrun=1; four reads return 8'h01..8'h04.
REQ-041 Framing/false start:
- frame 8'h55 with stop=0 -> frame_err=1, queue empty;
- a 1-cycle low glitch on rxd -> no push.
REQ-042 Reset mid-transmit: assert rstn=0 during TX_DATA -> txd=1 the next cycle; no uart_done; a following send of 8'hFF completes normally.
